// File: rtl/ili_spi_tx_pkg.sv
// Shared types and constants for the ILI9341 SPI byte transmitter.
// The state enum and default clock divider are used by the top and the bench.
package ili_spi_tx_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam int SPI_DW      = 8;
  localparam int SPI_CLK_DIV = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    DONE     = 3'd3,
    REARM    = 3'd4
  } spi_state_t;

endpackage

// File: rtl/ili_spi_clkdiv.sv
// Loadable down-counter that times one SCLK half-period.
// tc is high while the count sits at zero; a load restarts the half-period.
module ili_spi_clkdiv #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("ili_spi_clkdiv: CLK_DIV must be at least 1");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(CLK_DIV - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/ili_spi_tx.sv
// MSB-first SPI mode-0 byte transmitter for the ILI9341 panel.
// Accepts one byte per send request and acknowledges with a single-cycle sent pulse.
module ili_spi_tx
  import ili_spi_tx_pkg::*;
#(
  parameter int DW      = SPI_DW,
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          send,
  input  logic [DW-1:0] data,
  input  logic          dc_in,
  input  logic          cs_in,
  output logic          sent,
  output logic          busy,
  output logic          spi_sclk,
  output logic          spi_mosi,
  output logic          spi_dc,
  output logic          spi_cs
);

  localparam int BW = (DW > 1) ? $clog2(DW) : 1;

  spi_state_t    state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic          dc_q, dc_d;
  logic          cs_q;
  logic          sclk_q, sclk_d;
  logic          sent_q, sent_d;
  logic          busy_q, busy_d;
  logic          div_load;
  logic          div_en;
  logic          div_tc;

  ili_spi_clkdiv #(
    .CLK_DIV(CLK_DIV)
  ) u_clkdiv (
    .clk (clk),
    .rst (rst),
    .load(div_load),
    .en  (div_en),
    .tc  (div_tc)
  );

  assign div_en = (state_q == SHIFT_LO) || (state_q == SHIFT_HI);

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    dc_d     = dc_q;
    div_load = LOW;
    unique case (state_q)
      IDLE: begin
        if (send) begin
          state_d  = SHIFT_LO;
          shreg_d  = data;
          dc_d     = dc_in;
          bit_d    = BW'(DW - 1);
          div_load = HIGH;
        end
      end
      SHIFT_LO: begin
        if (div_tc) begin
          state_d  = SHIFT_HI;
          div_load = HIGH;
        end
      end
      SHIFT_HI: begin
        if (div_tc) begin
          div_load = HIGH;
          if (bit_q == '0) begin
            state_d = DONE;
          end else begin
            // Shift on the falling transition so MOSI is stable across the next rise.
            bit_d   = bit_q - 1'b1;
            shreg_d = shreg_q << 1;
            state_d = SHIFT_LO;
          end
        end
      end
      DONE: begin
        state_d = REARM;
      end
      REARM: begin
        // A send still held from the previous byte must not start another one.
        if (!send) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so the panel pins never glitch.
  always_comb begin
    sclk_d = (state_d == SHIFT_HI);
    sent_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      shreg_q <= '0;
      dc_q    <= HIGH;
      cs_q    <= HIGH;
      sclk_q  <= LOW;
      sent_q  <= LOW;
      busy_q  <= LOW;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      dc_q    <= dc_d;
      cs_q    <= cs_in;
      sclk_q  <= sclk_d;
      sent_q  <= sent_d;
      busy_q  <= busy_d;
    end
  end

  assign spi_sclk = sclk_q;
  assign spi_mosi = shreg_q[DW-1];
  assign spi_dc   = dc_q;
  assign spi_cs   = cs_q;
  assign sent     = sent_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_ili_spi_tx.sv
// Directed bench for ili_spi_tx: one instance at CLK_DIV=2 and one at CLK_DIV=1.
// Cycle c=1 is the cycle right after the accept edge; outputs are sampled on negedges.
module tb_ili_spi_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       send, send1;
  logic [7:0] data;
  logic       dc_in, cs_in;

  logic sent, busy, spi_sclk, spi_mosi, spi_dc, spi_cs;
  logic sent1, busy1, spi_sclk1, spi_mosi1, spi_dc1, spi_cs1;

  logic sel;
  logic m_sclk, m_mosi, m_dc, m_sent;

  int n_err = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  ili_spi_tx #(.DW(8), .CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .send(send), .data(data), .dc_in(dc_in), .cs_in(cs_in),
    .sent(sent), .busy(busy), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_dc(spi_dc), .spi_cs(spi_cs)
  );

  ili_spi_tx #(.DW(8), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .send(send1), .data(data), .dc_in(dc_in), .cs_in(cs_in),
    .sent(sent1), .busy(busy1), .spi_sclk(spi_sclk1), .spi_mosi(spi_mosi1),
    .spi_dc(spi_dc1), .spi_cs(spi_cs1)
  );

  assign m_sclk = sel ? spi_sclk1 : spi_sclk;
  assign m_mosi = sel ? spi_mosi1 : spi_mosi;
  assign m_dc   = sel ? spi_dc1   : spi_dc;
  assign m_sent = sel ? sent1     : sent;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_send(input logic v);
    if (sel) send1 = v;
    else     send  = v;
  endtask

  // Call at a negedge with send already high; the following posedge accepts.
  task automatic capture(input int div, input logic exp_dc, input int disturb_at,
                         input bit pulse, output logic [7:0] got, output int rises,
                         output int sent_cyc, output int first_rise, output int dc_bad,
                         output int hi_bad);
    logic prev;
    int   hi_len;
    prev = 1'b0; hi_len = 0;
    got = 8'h00; rises = 0; sent_cyc = -1; first_rise = -1; dc_bad = 0; hi_bad = 0;
    for (int c = 1; c <= 200 && sent_cyc < 0; c++) begin
      @(negedge clk);
      if (pulse && c == 1) set_send(1'b0);
      if (m_sclk && !prev) begin
        got = {got[6:0], m_mosi};
        rises++;
        hi_len = 0;
        if (first_rise < 0) first_rise = c;
        if (rises == disturb_at) begin
          data  = 8'h00;
          dc_in = ~exp_dc;
        end
      end
      if (m_sclk) hi_len++;
      if (!m_sclk && prev && hi_len != div) hi_bad++;
      if (m_sent) sent_cyc = c;
      if (m_dc !== exp_dc) dc_bad++;
      prev = m_sclk;
    end
    $display("byte: got=%02h rises=%0d sent_cycle=%0d first_rise=%0d", got, rises, sent_cyc, first_rise);
  endtask

  logic [7:0] got;
  int rises, sent_cyc, first_rise, dc_bad, hi_bad, bad;
  logic prev;

  initial begin
    rst = 1'b0; send = 1'b0; send1 = 1'b0; data = 8'h00; dc_in = 1'b0; cs_in = 1'b1; sel = 1'b0;

    // Reset asserted mid-cycle, before any clock edge: outputs must settle at once.
    #2 rst = 1'b1;
    #1;
    check("rst_async_cs",   32'(spi_cs),   32'd1);
    check("rst_async_dc",   32'(spi_dc),   32'd1);
    check("rst_async_sclk", 32'(spi_sclk), 32'd0);
    check("rst_async_mosi", 32'(spi_mosi), 32'd0);
    check("rst_async_sent", 32'(sent),     32'd0);
    check("rst_async_busy", 32'(busy),     32'd0);
    repeat (3) @(negedge clk);
    check("rst_hold_cs",   32'(spi_cs),   32'd1);
    check("rst_hold_busy", 32'(busy),     32'd0);
    check("rst_hold_dut1", 32'({busy1, sent1, spi_sclk1, spi_dc1, spi_cs1}), 32'b00011);
    rst = 1'b0;
    @(negedge clk);

    // Single command byte 0x2A, send held.
    cs_in = 1'b0; data = 8'h2A; dc_in = 1'b0; send = 1'b1;
    capture(2, 1'b0, -1, 1'b0, got, rises, sent_cyc, first_rise, dc_bad, hi_bad);
    check("cmd_data",       32'(got),        32'h2A);
    check("cmd_rises",      32'(rises),      32'd8);
    check("cmd_sent_cycle", 32'(sent_cyc),   32'd33);
    check("cmd_first_rise", 32'(first_rise), 32'd3);
    check("cmd_dc_stable",  32'(dc_bad),     32'd0);
    check("cmd_high_len",   32'(hi_bad),     32'd0);
    check("cmd_cs",         32'(spi_cs),     32'd0);

    // Send still held for 5 cycles: no second byte, one-cycle sent, busy held.
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sent !== 1'b0 || spi_sclk !== 1'b0 || busy !== 1'b1) bad++;
    end
    check("held_no_retx", 32'(bad), 32'd0);
    send = 1'b0;
    @(negedge clk);
    check("held_busy_drop", 32'(busy), 32'd0);

    // Data byte 0xFF with a one-cycle send pulse.
    data = 8'hFF; dc_in = 1'b1; send = 1'b1;
    capture(2, 1'b1, -1, 1'b1, got, rises, sent_cyc, first_rise, dc_bad, hi_bad);
    check("ff_data",       32'(got),      32'hFF);
    check("ff_sent_cycle", 32'(sent_cyc), 32'd33);
    check("ff_dc",         32'(dc_bad),   32'd0);
    repeat (2) @(negedge clk);
    check("ff_idle", 32'(busy), 32'd0);

    // Inputs change after the 3rd rise; the latched byte and dc must win.
    data = 8'hA5; dc_in = 1'b0; send = 1'b1;
    capture(2, 1'b0, 3, 1'b0, got, rises, sent_cyc, first_rise, dc_bad, hi_bad);
    check("dist_data", 32'(got),    32'hA5);
    check("dist_dc",   32'(dc_bad), 32'd0);
    check("dist_rises", 32'(rises), 32'd8);
    send = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during the 5th bit of 0x3C (MOSI=1, SCLK high at that point).
    data = 8'h3C; dc_in = 1'b0; send = 1'b1;
    rises = 0; prev = 1'b0;
    for (int c = 0; c < 100 && rises < 5; c++) begin
      @(negedge clk);
      if (spi_sclk && !prev) rises++;
      prev = spi_sclk;
    end
    check("midrst_reached", 32'(rises), 32'd5);
    send = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_outs", 32'({spi_sclk, spi_mosi, spi_dc, sent, busy}), 32'b00100);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (sent !== 1'b0 || spi_sclk !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("midrst_no_resume", 32'(bad), 32'd0);
    data = 8'h96; dc_in = 1'b1; send = 1'b1;
    capture(2, 1'b1, -1, 1'b0, got, rises, sent_cyc, first_rise, dc_bad, hi_bad);
    check("fresh_data",       32'(got),      32'h96);
    check("fresh_sent_cycle", 32'(sent_cyc), 32'd33);
    send = 1'b0;
    repeat (2) @(negedge clk);

    // CLK_DIV=1 instance: SCLK toggles every cycle.
    sel = 1'b1;
    data = 8'h81; dc_in = 1'b1; send1 = 1'b1;
    capture(1, 1'b1, -1, 1'b0, got, rises, sent_cyc, first_rise, dc_bad, hi_bad);
    check("div1_data",       32'(got),        32'h81);
    check("div1_rises",      32'(rises),      32'd8);
    check("div1_sent_cycle", 32'(sent_cyc),   32'd17);
    check("div1_first_rise", 32'(first_rise), 32'd2);
    check("div1_high_len",   32'(hi_bad),     32'd0);
    @(negedge clk);
    check("div1_sent_pulse", 32'(sent1), 32'd0);
    send1 = 1'b0;
    repeat (2) @(negedge clk);
    check("div1_idle", 32'(busy1), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ili_spi_tx.md
Name: ili_spi_tx

Overview:
- Byte-level SPI transmitter for the ILI9341 panel.
- Sits directly downstream of the init/command controller: consumes its data, dc, cs and send, and returns a one-cycle sent acknowledge.
- Serialises each byte MSB-first in SPI mode 0 (CPOL=0, CPHA=0) onto the panel pins; dc is held stable for the whole byte.

Parameters:
- DW, 8: bits per transfer.
- CLK_DIV, 2: clk cycles per SCLK half-period; must be ≥1 (elaboration-time check).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- send  in  1  transfer request; level, held high by upstream until sent.
- data  in  DW  byte to transmit; sampled at accept.
- dc_in  in  1  0=command, 1=data; sampled at accept.
- cs_in  in  1  chip-select request from upstream, active low.
- sent  out  1  one-cycle pulse when the byte is fully shifted.
- busy  out  1  high from accept until return to IDLE.
- spi_sclk  out  1  serial clock; idles low.
- spi_mosi  out  1  serial data.
- spi_dc  out  1  latched dc to panel.
- spi_cs  out  1  registered copy of cs_in, active low.

Behaviour:
- Reset (async, active-high, also mid-transfer):
  - State IDLE; all counters cleared; shift register cleared.
  - Outputs: spi_sclk=0, spi_mosi=0, spi_dc=1, spi_cs=1, sent=0, busy=0.
  - On reset release, no partial byte resumes.
- spi_cs: registered cs_in with 1-cycle latency, independent of state. The block never aborts a byte on cs_in deassertion; framing is upstream's responsibility.
- State IDLE: when send=1 at a clk edge → latch data into shreg, latch dc_in into spi_dc. spi_mosi=data[DW-1], busy=1, enter SHIFT_LO, phase counter=CLK_DIV-1, bit counter=DW-1.
- State SHIFT_LO: spi_sclk=0 for CLK_DIV cycles. When the phase counter reaches 0 → SHIFT_HI, counter reloads.
- State SHIFT_HI: spi_sclk=1 for CLK_DIV cycles; the panel samples on this rising edge. When the phase counter reaches 0:
  - If bit counter=0 → DONE.
  - Else bit counter decrements, shreg shifts left, spi_mosi takes the next bit, → SHIFT_LO.
- State DONE: spi_sclk=0, sent=1 for exactly one cycle → REARM.
- State REARM: sent=0; wait for send=0, then → IDLE.
  - A send still high here is never treated as a new request, so no double transmission occurs.
  - busy drops on entry to IDLE.
- Latency:
  - Accept edge to first SCLK rise: CLK_DIV cycles.
  - Accept edge to sent high: 2·CLK_DIV·DW cycles plus 1 edge.
  - Example: DW=8, CLK_DIV=2 gives 32 shift cycles, with sent high in the 33rd cycle after accept.
- Stability:
  - spi_mosi changes only on SCLK falling transitions or at accept.
  - data and dc_in changes during a transfer are ignored.
  - spi_dc holds its value until the next accept.
- Back-to-back requests: the minimum gap between sent pulses is transfer time plus 2 cycles (DONE, REARM with send low, IDLE accept).
- Counter widths: phase counter $clog2(CLK_DIV+1); bit counter $clog2(DW). No wrap-around in either, because reloads are explicit.
- If send and rst rise simultaneously, reset wins.

Decomposition:
- pkg_ili9341 gains:
  - the spi_state_t enum {IDLE, SHIFT_LO, SHIFT_HI, DONE, REARM};
  - the SPI_CLK_DIV default constant.
- HIGH/LOW constants are reused from the package.
- One natural sub-module: ili_spi_clkdiv, a loadable down-counter with a terminal-count tick (parameter CLK_DIV), instantiated for phase timing.

Test Plan:
- Reset then idle: assert rst mid-cycle, hold 3 cycles → spi_cs=1, spi_dc=1, spi_sclk=0, spi_mosi=0, sent=0, busy=0, with outputs changing asynchronously.
- Single command: data=0x2A, dc_in=0, send held high, CLK_DIV=2 → 8 SCLK pulses, each high for 2 cycles.
  - MOSI sampled at each rise reads 0,0,1,0,1,0,1,0 and spi_dc=0 throughout.
  - sent high exactly one cycle, 33 cycles after accept.
- Held send: keep send=1 for 5 cycles after sent → exactly one byte transmitted and busy stays high until send drops. Then data=0xFF, dc_in=1 with send pulsed → second byte 0xFF with spi_dc=1.
- Mid-transfer disturbance: change data to 0x00 and dc_in to 1 after the 3rd SCLK rise of 0xA5 → the full 0xA5 is still shifted and spi_dc stays at its latched value.
- Reset mid-operation: assert rst during the 5th bit → immediate return to reset values and no sent pulse. A new send after release transmits a complete fresh byte.
- CLK_DIV=1 corner: data=0x81 → SCLK toggles every cycle, 16 shift cycles, MOSI reads 1,0,0,0,0,0,0,1.
